vnu: RTL

Variable node unit for the layered-free flooding LDPC decoder. It sits directly upstream of the check node unit and closes the message loop with it:
- It takes one variable node's channel LLR and its DV incoming check-to-variable messages.
- It produces the DV extrinsic variable-to-check messages, the saturated posterior, and the hard decision.
- It is a two-stage pipeline with valid/ready handshakes on both sides and sustains one node per cycle.

---
 rtl/ldpc_pkg.sv | 28 ++
 rtl/sat_sym.sv | 30 +++
 rtl/vnu.sv | 105 ++++++++++
 3 files changed

// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder package.
// Purpose: width helpers used by the variable node unit and the check node
// unit so both sides of the message loop agree on word and sum widths.
//   log2    - ceiling log2 of a positive integer
//   sum_w   - internal accumulator width for a node of degree dv
//   sat_max - largest magnitude emitted by symmetric saturation
package ldpc_pkg;

  function automatic int log2(input int v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << n) < v) n = n + 1;
    end
    return n;
  endfunction

  // One extra bit on top of the growth term keeps L plus DV messages
  // (all possibly at the most negative code) clear of overflow.
  function automatic int sum_w(input int data_w, input int dv);
    return data_w + log2(dv + 1) + 1;
  endfunction

  function automatic int sat_max(input int data_w);
    return (1 << (data_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/sat_sym.sv
// Symmetric saturation from in_w bits down to data_w bits.
// Purpose: clamp a signed value to [-(2^(data_w-1)-1), +(2^(data_w-1)-1)] so
// the most negative code never leaves the variable node and the downstream
// negation cannot overflow.
// Ports:
//   d - signed input, in_w bits
//   q - clamped signed output, data_w bits
module sat_sym
  import ldpc_pkg::*;
#(
  parameter int in_w   = 11,
  parameter int data_w = 8
) (
  input  logic [in_w-1:0]   d,
  output logic [data_w-1:0] q
);

  localparam int MAX_I = sat_max(data_w);
  localparam logic signed [in_w-1:0] MAX_V = in_w'(MAX_I);
  localparam logic signed [in_w-1:0] MIN_V = in_w'(-MAX_I);

  function automatic logic [data_w-1:0] clamp(input logic signed [in_w-1:0] x);
    if (x > MAX_V) return MAX_V[data_w-1:0];
    else if (x < MIN_V) return MIN_V[data_w-1:0];
    else return x[data_w-1:0];
  endfunction

  assign q = clamp($signed(d));

endmodule

// File: rtl/vnu.sv
// Variable node unit for the flooding LDPC decoder.
// Purpose: from one channel LLR and DV check-to-variable messages, produce DV
// extrinsic variable-to-check messages, the saturated posterior and the hard
// decision. Two-stage pipeline, one node per cycle, valid/ready on both sides.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   in_valid/in_ready - input handshake for L and r
//   L                 - channel LLR (data_w, two's complement)
//   r                 - DV messages, edge j at [j*data_w +: data_w]
//   out_valid/out_ready - output handshake for q, app, hd
//   q                 - DV extrinsic messages, same packing as r
//   app               - saturated posterior LLR
//   hd                - hard decision, 1 when the posterior sum is negative
module vnu
  import ldpc_pkg::*;
#(
  parameter int DV     = 3,
  parameter int data_w = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [data_w-1:0]      L,
  input  logic [data_w*DV-1:0]   r,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [data_w*DV-1:0]   q,
  output logic [data_w-1:0]      app,
  output logic                   hd
);

  localparam int SW = sum_w(data_w, DV);

  logic                        vld_p1, vld_p2;
  logic                        adv_p1, adv_p2;
  logic signed [SW-1:0]        sum_c;
  logic signed [SW-1:0]        sum_p1;
  logic [data_w*DV-1:0]        r_p1;
  logic signed [SW-1:0]        diff_c [DV];
  logic [data_w*DV-1:0]        q_c;
  logic [data_w-1:0]           app_c;
  logic [data_w*DV-1:0]        q_p2;
  logic [data_w-1:0]           app_p2;
  logic                        hd_p2;

  assign adv_p2    = !vld_p2 || out_ready;
  assign adv_p1    = !vld_p1 || adv_p2;
  assign in_ready  = adv_p1;
  assign out_valid = vld_p2;
  assign q         = q_p2;
  assign app       = app_p2;
  assign hd        = hd_p2;

  always_comb begin
    sum_c = SW'($signed(L));
    for (int j = 0; j < DV; j++) begin
      sum_c = sum_c + SW'($signed(r[j*data_w +: data_w]));
    end
  end

  for (genvar j = 0; j < DV; j++) begin : g_edge
    assign diff_c[j] = sum_p1 - SW'($signed(r_p1[j*data_w +: data_w]));
    sat_sym #(.in_w(SW), .data_w(data_w)) u_sat_q (
      .d (diff_c[j]),
      .q (q_c[j*data_w +: data_w])
    );
  end

  sat_sym #(.in_w(SW), .data_w(data_w)) u_sat_app (
    .d (sum_p1),
    .q (app_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      sum_p1 <= '0;
      r_p1   <= '0;
      vld_p2 <= 1'b0;
      q_p2   <= '0;
      app_p2 <= '0;
      hd_p2  <= 1'b0;
    end else begin
      // Stage 1: full-width sum and a copy of the incoming messages
      if (adv_p1) begin
        vld_p1 <= in_valid;
        if (in_valid) begin
          sum_p1 <= sum_c;
          r_p1   <= r;
        end
      end
      // Stage 2: extrinsic subtraction, saturation and hard decision
      if (adv_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          q_p2   <= q_c;
          app_p2 <= app_c;
          hd_p2  <= sum_p1[SW-1];
        end
      end
    end
  end

endmodule
